// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: reset vector, canonical NOP encoding
// and the {pc, inst} entry carried through the fetch buffer.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO of fetch entries with a
// registered head, single-cycle flush and simultaneous push/pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; consumers only look at it when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// capture into the prefetch buffer, and redirect handling that drains stale responses.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memGnt,
  input  logic        memRvalid,
  input  logic [31:0] memRdata,
  output logic        instValid,
  output logic [31:0] inst,
  output logic [31:0] instPC,
  input  logic        instReady
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fpc_q, fpc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             started_q;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             fifo_full, fifo_empty;
  logic             grant, rsp_keep, pop;
  fetch_entry_t     push_entry, head;

  assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign memReq    = started_q && !fifo_full && (occupancy < (CNT_W + 1)'(DEPTH));
  assign memAddr   = fpc_q;
  assign grant     = memReq && memGnt;
  assign rsp_keep  = memRvalid && !redirect && (drop_q == '0);

  // With no drops pending, every in-flight request was issued contiguously up
  // to fpc, so the oldest one sits one word back per outstanding request.
  assign push_entry.pc   = fpc_q - (32'(inflight_q) << 2);
  assign push_entry.inst = memRdata;

  assign instValid = !fifo_empty;
  assign pop       = instValid && instReady && !redirect;
  assign inst      = fifo_empty ? '0 : head.inst;
  assign instPC    = fifo_empty ? '0 : head.pc;

  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (grant) begin
      fpc_d      = fpc_q + 32'd4;
      inflight_d = inflight_d + CNT_W'(1);
    end
    if (memRvalid) begin
      inflight_d = inflight_d - CNT_W'(1);
      if (drop_q != '0) drop_d = drop_q - CNT_W'(1);
    end
    // Everything still outstanding after this cycle belongs to the old path.
    if (redirect) begin
      fpc_d  = redirectPC & ~32'h3;
      drop_d = inflight_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q      <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      started_q  <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      started_q  <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (rsp_keep),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule
